// File: rtl/rst_sequencer.sv
// Staged reset sequencer: holds every channel in reset for a programmable
// time after the last reset cause, then releases channels in index order with
// a fixed gap. Software can restart the sequence through a req/ack handshake.
module rst_sequencer #(
  parameter int unsigned NUM_CH      = 3,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned STAGE_GAP   = 2,
  parameter int unsigned CNTW        =
    $clog2(((HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP) + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              soft_rst_req_i,
  output logic              soft_rst_ack_o,
  output logic [NUM_CH-1:0] rst_o,
  output logic              all_rel_o,
  output logic              busy_o
);

  localparam int unsigned CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [CNTW-1:0] HoldLoad = CNTW'(HOLD_CYCLES - 1);
  localparam logic [CNTW-1:0] GapLoad  = CNTW'(STAGE_GAP - 1);
  localparam logic [CHW-1:0]  LastCh   = CHW'(NUM_CH - 1);

  typedef enum logic [1:0] {
    StHold,
    StRelease,
    StRun
  } state_e;

  state_e            state, state_next;
  logic [CNTW-1:0]   cnt, cnt_next;
  logic [CHW-1:0]    ch, ch_next;
  logic [NUM_CH-1:0] rst_q, rst_next;
  logic              ack_q, ack_next;

  // State register; rst_i overrides everything, including a pending soft request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= StHold;
      cnt   <= HoldLoad;
      ch    <= '0;
      rst_q <= '1;
      ack_q <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      ch    <= ch_next;
      rst_q <= rst_next;
      ack_q <= ack_next;
    end
  end

  // Next-state: count down the hold, then clear one channel per gap expiry.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    ch_next    = ch;
    rst_next   = rst_q;
    ack_next   = 1'b0;
    unique case (state)
      StHold: begin
        if (cnt == '0) begin
          rst_next[0] = 1'b0;
          if (NUM_CH == 1) begin
            state_next = StRun;
          end else begin
            state_next = StRelease;
            ch_next    = CHW'(1);
            cnt_next   = GapLoad;
          end
        end else begin
          cnt_next = cnt - CNTW'(1);
        end
      end
      StRelease: begin
        if (cnt == '0) begin
          for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (ch == CHW'(k)) rst_next[k] = 1'b0;
          end
          ch_next  = ch + CHW'(1);
          cnt_next = GapLoad;
          if (ch == LastCh) state_next = StRun;
        end else begin
          cnt_next = cnt - CNTW'(1);
        end
      end
      StRun: begin
        rst_next = '0;
        // Soft requests are only honoured once the previous sequence completed.
        if (soft_rst_req_i) begin
          state_next = StHold;
          cnt_next   = HoldLoad;
          ch_next    = '0;
          rst_next   = '1;
          ack_next   = 1'b1;
        end
      end
      default: begin
        state_next = StHold;
        cnt_next   = HoldLoad;
        ch_next    = '0;
        rst_next   = '1;
      end
    endcase
  end

  assign rst_o          = rst_q;
  assign soft_rst_ack_o = ack_q;
  assign all_rel_o      = (state == StRun);
  assign busy_o         = (state != StRun);

endmodule
